fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit_buffer.sv | 34 +++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, defaults and the {pc, inst} entry type for the fetch stage.
package fetch_unit_pkg;
  localparam int WORD_SIZE = 32;
  localparam int INST_BYTES = 4;
  localparam int MISS_PENALTY = 4;
  typedef logic [WORD_SIZE-1:0] word_t;
  localparam word_t RESET_PC = '0;
  typedef struct packed {
    word_t pc;
    word_t inst;
  } entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: cache, redirect and decode-side signals of the fetch stage.
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  word_t cache_ptr;
  logic cache_enable;
  logic cache_hit;
  word_t cache_inst;
  logic redirect_valid;
  word_t redirect_pc;
  logic out_valid;
  logic out_ready;
  word_t out_pc;
  word_t out_inst;
  logic [15:0] miss_count;
  modport master (
    output cache_ptr, cache_enable, out_valid, out_pc, out_inst, miss_count,
    input cache_hit, cache_inst, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input cache_ptr, cache_enable, out_valid, out_pc, out_inst, miss_count,
    output cache_hit, cache_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_unit_buffer: 2-entry {pc, inst} FIFO whose head register drives decode directly.
module fetch_unit_buffer
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       enq,
  input  logic       deq,
  input  entry_t     enq_data,
  output logic       out_valid,
  output entry_t     out_data,
  output logic [1:0] count
);
  entry_t tail;
  assign out_valid = count != 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      out_data <= '0;
      tail <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'(enq) - 2'(deq);
      if (enq && (count == 2'd0 || (count == 2'd1 && deq)))
        out_data <= enq_data;
      else if (deq && count == 2'd2)
        out_data <= tail;
      if (enq && ((count == 2'd1 && !deq) || (count == 2'd2 && deq)))
        tail <= enq_data;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues to inst_cache, replays misses after a penalty and applies redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int    INST_BYTES   = fetch_unit_pkg::INST_BYTES,
  parameter word_t RESET_PC     = fetch_unit_pkg::RESET_PC,
  parameter int    MISS_PENALTY = fetch_unit_pkg::MISS_PENALTY
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);
  typedef enum logic {RUN, MISS_WAIT} state_t;
  localparam word_t STEP = word_t'(INST_BYTES);
  localparam word_t ALIGN = ~(STEP - word_t'(1));
  localparam logic [3:0] PENALTY = 4'(MISS_PENALTY);
  state_t state;
  word_t fetch_pc, inflight_pc;
  logic inflight, deq, enq, resp_miss, issue;
  logic [3:0] wait_cnt;
  logic [1:0] count;
  logic [15:0] miss_count;
  entry_t resp, head;
  assign deq = bus.out_valid && bus.out_ready;
  assign resp_miss = inflight && !bus.cache_hit;
  assign enq = inflight && bus.cache_hit && !bus.redirect_valid;
  assign resp = '{pc: inflight_pc, inst: bus.cache_inst};
  // Slot check reserves room for the response of anything issued now.
  assign issue = !rst && state == RUN && !bus.redirect_valid && !resp_miss &&
                 ({1'b0, count} + {2'b0, inflight} - {2'b0, deq} < 3'd2);
  assign bus.cache_enable = issue;
  assign bus.cache_ptr = fetch_pc;
  assign bus.miss_count = miss_count;
  assign bus.out_pc = head.pc;
  assign bus.out_inst = head.inst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      inflight_pc <= '0;
      inflight <= 1'b0;
      wait_cnt <= 4'd0;
      miss_count <= 16'd0;
    end else if (bus.redirect_valid) begin
      state <= RUN;
      fetch_pc <= bus.redirect_pc & ALIGN;
      inflight <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + STEP;
      end
      if (resp_miss) begin
        fetch_pc <= inflight_pc;
        miss_count <= miss_count + 16'(~&miss_count);
        wait_cnt <= PENALTY;
        state <= MISS_WAIT;
      end
      if (state == MISS_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
        state <= wait_cnt == 4'd1 ? RUN : MISS_WAIT;
      end
    end
  end
  fetch_unit_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect_valid),
    .enq(enq),
    .deq(deq),
    .enq_data(resp),
    .out_valid(bus.out_valid),
    .out_data(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a registered cache model and an in-order stream model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  fetch_unit_if bus();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit warm = 0;
  bit resp_v = 0;
  bit present [int];
  word_t exp_pc = RESET_PC;
  word_t held_pc, held_inst;
  bit held = 0;
  logic [15:0] exp_miss = 0;

  function automatic word_t inst_of(word_t pc);
    return pc ^ 32'hC0DE_0F0F;
  endfunction

  function automatic void check(string name, word_t act, word_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_out(input word_t pc, input int budget, input string name);
    int n = 0;
    do begin
      step();
      mid();
      n++;
    end while (!(bus.out_valid && bus.out_pc == pc) && n < budget);
    check(name, word_t'(bus.out_valid && bus.out_pc == pc), 1);
  endtask

  // inst_cache stand-in: 16-byte lines, a miss fills the line, response one cycle after issue.
  initial begin
    bit en;
    word_t p;
    bus.cache_hit = 0;
    bus.cache_inst = 0;
    forever begin
      @(negedge clk);
      en = bus.cache_enable;
      p = bus.cache_ptr;
      @(posedge clk);
      #2;
      resp_v = en;
      if (en) begin
        bus.cache_hit = warm || present.exists(int'(p >> 4));
        present[int'(p >> 4)] = 1;
        bus.cache_inst = inst_of(p);
      end
    end
  end

  // Stream model: handshakes deliver consecutive pcs, restarting at each aligned redirect target.
  always @(negedge clk) begin
    check("miss_count", word_t'(bus.miss_count), word_t'(exp_miss));
    if (held) begin
      check("hold_valid", word_t'(bus.out_valid), 1);
      check("hold_pc", bus.out_pc, held_pc);
      check("hold_inst", bus.out_inst, held_inst);
    end
    if (rst) begin
      exp_pc = RESET_PC;
      exp_miss = 0;
      held = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check("out_pc", bus.out_pc, exp_pc);
        check("out_inst", bus.out_inst, inst_of(exp_pc));
        exp_pc += 4;
      end
      held = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
      held_pc = bus.out_pc;
      held_inst = bus.out_inst;
      if (resp_v && !bus.cache_hit && !bus.redirect_valid && exp_miss != 16'hFFFF) exp_miss++;
      if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'd3;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    // cold start
    step(); mid();
    check("rst_enable", word_t'(bus.cache_enable), 0);
    check("rst_valid", word_t'(bus.out_valid), 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_inst", bus.out_inst, 0);
    check("rst_miss", word_t'(bus.miss_count), 0);
    step(); rst = 0; cyc = 0; mid();
    check("a_issue_en", word_t'(bus.cache_enable), 1);
    check("a_issue_ptr", bus.cache_ptr, 0);
    step(); mid();
    check("a_miss_en", word_t'(bus.cache_enable), 0);
    for (int i = 2; i <= 5; i++) begin
      step(); mid();
      check("a_wait_en", word_t'(bus.cache_enable), 0);
    end
    step(); mid();
    check("a_replay_en", word_t'(bus.cache_enable), 1);
    check("a_replay_ptr", bus.cache_ptr, 0);
    step(); mid();
    check("a_c7_valid", word_t'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      check("a_out_valid", word_t'(bus.out_valid), 1);
      check("a_out_pc", bus.out_pc, word_t'(4 * i));
    end
    step(); mid();
    check("a_gap_valid", word_t'(bus.out_valid), 0);
    wait_out(32'h10, 20, "a_pc10_seen");
    check("a_pc10_cycle", word_t'(cyc), 18);
    check("a_miss2", word_t'(bus.miss_count), 2);
    // warm cache, decode stalled for 10 cycles
    step(); rst = 1; warm = 1; bus.out_ready = 0;
    step(); rst = 0; cyc = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (i >= 3) begin
        check("b_full_valid", word_t'(bus.out_valid), 1);
        check("b_full_pc", bus.out_pc, 0);
        check("b_full_en", word_t'(bus.cache_enable), 0);
      end
      step();
    end
    bus.out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      mid();
      check("b_stream_valid", word_t'(bus.out_valid), 1);
      check("b_stream_pc", bus.out_pc, word_t'(4 * i));
      step();
    end
    // redirect together with a handshake
    bus.redirect_valid = 1; bus.redirect_pc = 32'h103; mid();
    check("c_hs_valid", word_t'(bus.out_valid), 1);
    step(); bus.redirect_valid = 0; mid();
    check("c_en", word_t'(bus.cache_enable), 1);
    check("c_ptr", bus.cache_ptr, 32'h100);
    check("c_flushed", word_t'(bus.out_valid), 0);
    step(); step(); mid();
    check("c_valid", word_t'(bus.out_valid), 1);
    check("c_pc", bus.out_pc, 32'h100);
    // redirect while waiting out a miss penalty
    step(); warm = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h200;
    step(); bus.redirect_valid = 0;
    step(); mid();
    check("d_miss_en", word_t'(bus.cache_enable), 0);
    step(); step(); mid();
    check("d_wait_en", word_t'(bus.cache_enable), 0);
    step(); warm = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h300;
    step(); bus.redirect_valid = 0; mid();
    check("d_en", word_t'(bus.cache_enable), 1);
    check("d_ptr", bus.cache_ptr, 32'h300);
    step(); step(); mid();
    check("d_valid", word_t'(bus.out_valid), 1);
    check("d_pc", bus.out_pc, 32'h300);
    check("d_miss1", word_t'(bus.miss_count), 1);
    // wrap at the top of the address space
    step(); bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
    step(); bus.redirect_valid = 0;
    step(); step(); mid();
    check("e_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    step(); mid();
    check("e_valid_wrap", word_t'(bus.out_valid), 1);
    check("e_pc_wrap", bus.out_pc, 32'h0);
    // reset during a miss penalty with a stalled, occupied buffer
    step(); warm = 0; present[int'(32'h50)] = 1; bus.out_ready = 0;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h50C;
    step(); bus.redirect_valid = 0;
    step(); step(); step(); mid();
    check("f_pre_valid", word_t'(bus.out_valid), 1);
    check("f_pre_pc", bus.out_pc, 32'h50C);
    check("f_pre_en", word_t'(bus.cache_enable), 0);
    check("f_pre_miss", word_t'(bus.miss_count), 2);
    step(); rst = 1; mid();
    check("f_rst_en", word_t'(bus.cache_enable), 0);
    step(); rst = 0; cyc = 0; mid();
    check("f_valid", word_t'(bus.out_valid), 0);
    check("f_miss", word_t'(bus.miss_count), 0);
    check("f_en", word_t'(bus.cache_enable), 1);
    check("f_ptr", bus.cache_ptr, RESET_PC);
    step(); bus.out_ready = 1;
    wait_out(RESET_PC, 20, "f_restart");
    step(); step(); mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
